// File: rtl/brc_seq_ctrl.sv
// rtl/brc_seq_ctrl.sv - multi-cycle chunked branch comparator with valid/ready request and response
// Optional early exit on first differing chunk: define BRC_EARLY_EXIT_EN.
module brc_seq_ctrl #(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [DATA_W-1:0] i_rs1_data,
    input  logic [DATA_W-1:0] i_rs2_data,
    input  logic [2:0]        i_funct3,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_br_taken,
    output logic              o_br_less,
    output logic              o_br_equal,
    output logic              o_illegal,
    output logic              o_busy
);

    localparam int N     = DATA_W / CHUNK_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  rs1_q, rs1_d;
    logic [DATA_W-1:0]  rs2_q, rs2_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               eq_q, eq_d;
    logic               lt_q, lt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               taken_q, taken_d;
    logic               less_q, less_d;
    logic               equal_q, equal_d;
    logic               illegal_q, illegal_d;

    logic [CHUNK_W-1:0] a_chunk;
    logic [CHUNK_W-1:0] b_chunk;
    logic               chunk_diff;
    logic               chunk_lt;
    logic               signed_sel;
    logic               cmp_exit;
    int                 base;

    function automatic logic taken_f(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'b000:         taken_f = eq;
            3'b001:         taken_f = ~eq;
            3'b100, 3'b110: taken_f = lt;
            3'b101, 3'b111: taken_f = ~lt;
            default:        taken_f = 1'b0;
        endcase
    endfunction

    always_comb begin
        base       = int'(idx_q) * CHUNK_W;
        a_chunk    = rs1_q[base +: CHUNK_W];
        b_chunk    = rs2_q[base +: CHUNK_W];
        chunk_diff = (a_chunk != b_chunk);
        // Only the most significant chunk carries the sign for BLT/BGE.
        signed_sel = (idx_q == IDX_W'(N - 1)) && !funct3_q[1];
        chunk_lt   = signed_sel ? ($signed(a_chunk) < $signed(b_chunk)) : (a_chunk < b_chunk);
`ifdef BRC_EARLY_EXIT_EN
        cmp_exit   = (idx_q == '0) || (eq_q && chunk_diff);
`else
        cmp_exit   = (idx_q == '0);
`endif

        state_d     = state_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        funct3_d    = funct3_q;
        idx_d       = idx_q;
        eq_d        = eq_q;
        lt_d        = lt_q;
        rsp_valid_d = rsp_valid_q;
        taken_d     = taken_q;
        less_d      = less_q;
        equal_d     = equal_q;
        illegal_d   = illegal_q;

        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    rs1_d    = i_rs1_data;
                    rs2_d    = i_rs2_data;
                    funct3_d = i_funct3;
                    idx_d    = IDX_W'(N - 1);
                    eq_d     = 1'b1;
                    lt_d     = 1'b0;
                    state_d  = S_CMP;
                end
            end
            S_CMP: begin
                // After the first differing chunk the verdict is frozen.
                if (eq_q) begin
                    lt_d = chunk_lt;
                    if (chunk_diff) eq_d = 1'b0;
                end
                if (cmp_exit) begin
                    state_d     = S_DONE;
                    rsp_valid_d = 1'b1;
                    equal_d     = eq_d;
                    less_d      = lt_d;
                    illegal_d   = (funct3_q[2:1] == 2'b01);
                    taken_d     = (funct3_q[2:1] == 2'b01) ? 1'b0 : taken_f(funct3_q, eq_d, lt_d);
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            S_DONE: begin
                if (i_rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    taken_d     = 1'b0;
                    less_d      = 1'b0;
                    equal_d     = 1'b0;
                    illegal_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            funct3_q    <= '0;
            idx_q       <= '0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            less_q      <= 1'b0;
            equal_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            funct3_q    <= funct3_d;
            idx_q       <= idx_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
            rsp_valid_q <= rsp_valid_d;
            taken_q     <= taken_d;
            less_q      <= less_d;
            equal_q     <= equal_d;
            illegal_q   <= illegal_d;
        end
    end

    assign o_req_ready = (state_q == S_IDLE) && !i_reset;
    assign o_busy      = (state_q != S_IDLE);
    assign o_rsp_valid = rsp_valid_q;
    assign o_br_taken  = taken_q;
    assign o_br_less   = less_q;
    assign o_br_equal  = equal_q;
    assign o_illegal   = illegal_q;

endmodule

// File: tb/tb_brc_seq_ctrl.sv
// tb/tb_brc_seq_ctrl.sv - directed table-driven bench for brc_seq_ctrl
module tb_brc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        taken, less, equal, illegal, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    brc_seq_ctrl #(.DATA_W(32), .CHUNK_W(8)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_rs1_data  (rs1),
        .i_rs2_data  (rs2),
        .i_funct3    (funct3),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_br_taken  (taken),
        .o_br_less   (less),
        .o_br_equal  (equal),
        .o_illegal   (illegal),
        .o_busy      (busy)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        taken;
        logic        less;
        logic        equal;
        logic        illegal;
        int          lat_fixed;
        int          lat_early;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int hold);
        int lat;
        @(negedge clk);
        rs1 = v.a; rs2 = v.b; funct3 = v.f3; req_valid = 1'b1;
        #1 chk("req_ready_idle", int'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rs1 = ~v.a; rs2 = v.a ^ 32'h5a5a_a5a5; funct3 = ~v.f3;
        chk("busy_after_accept", int'(busy), 1);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
`ifdef BRC_EARLY_EXIT_EN
        chk("latency", lat, v.lat_early);
`else
        chk("latency", lat, v.lat_fixed);
`endif
        chk("rsp_valid", int'(rsp_valid), 1);
        chk("taken", int'(taken), int'(v.taken));
        chk("less", int'(less), int'(v.less));
        chk("equal", int'(equal), int'(v.equal));
        chk("illegal", int'(illegal), int'(v.illegal));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", int'(rsp_valid), 1);
            chk("bp_taken", int'(taken), int'(v.taken));
            chk("bp_less", int'(less), int'(v.less));
            chk("bp_req_ready", int'(req_ready), 0);
            chk("bp_busy", int'(busy), 1);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("idle_rsp_valid", int'(rsp_valid), 0);
        chk("idle_req_ready", int'(req_ready), 1);
        chk("idle_taken", int'(taken), 0);
    endtask

    initial begin
        //            f3      rs1           rs2           tk  lt  eq  il  fix early
        vecs[0] = '{3'b000, 32'h12345678, 32'h12345678, 1, 0, 1, 0, 4, 4};
        vecs[1] = '{3'b100, 32'hFFFFFFFF, 32'h00000001, 1, 1, 0, 0, 4, 1};
        vecs[2] = '{3'b110, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 0, 4, 1};
        vecs[3] = '{3'b101, 32'h80000000, 32'h7FFFFFFF, 0, 1, 0, 0, 4, 1};
        vecs[4] = '{3'b101, 32'h00000001, 32'h00000002, 0, 1, 0, 0, 4, 4};
        vecs[5] = '{3'b010, 32'h00000000, 32'h00000000, 0, 0, 1, 1, 4, 4};
        vecs[6] = '{3'b111, 32'h00000100, 32'h000000FF, 1, 0, 0, 0, 4, 3};
        vecs[7] = '{3'b011, 32'h00000005, 32'h00000003, 0, 0, 0, 1, 4, 4};
        vecs[8] = '{3'b100, 32'h7F000000, 32'h80000000, 0, 0, 0, 0, 4, 1};
        vecs[9] = '{3'b001, 32'h00000000, 32'h00000001, 1, 1, 0, 0, 4, 4};

        #1;
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_taken", int'(taken), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_req_ready", int'(req_ready), 1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], 0);

        // Backpressure: three stalled cycles in DONE.
        run_vec(vecs[1], 3);

        // Reset two edges into CMP drops the response.
        @(negedge clk);
        rs1 = 32'h0; rs2 = 32'h1; funct3 = 3'b001; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
        chk("mid_rst_req_ready", int'(req_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("no_spurious_valid", int'(rsp_valid), 0);
        end
        run_vec(vecs[9], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
